muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width, any even value 8..64.
REQ-002 Parameter MUL_LAT, default 2: multiply latency in cycles from accept to commit, range 1..4.
REQ-003 CLK  input  1  clock, rising-edge active; one clock domain only.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request issue; sampled on the rising edge of CLK.
REQ-006 op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-007 rs  input  WIDTH  operand A: dividend, multiplicand, or move source.
REQ-008 rt  input  WIDTH  operand B: divisor or multiplier.
REQ-009 cancel  input  1  aborts the operation in flight.
REQ-010 busy  output  1  high while a MUL or DIV operation is in flight.
REQ-011 done  output  1  one-cycle pulse when a MUL or DIV result has been committed.
REQ-012 dz  output  1  divide-by-zero flag; valid only while done=1.
REQ-013 hi  output  WIDTH  registered HI.
REQ-014 lo  output  WIDTH  registered LO.

Function
REQ-015 Accept rule: a request is accepted on an edge where start=1, busy=0 and cancel=0; start is ignored otherwise.
REQ-016 States are IDLE, MUL, DIV and FIX; busy=1 in MUL, DIV and FIX; busy=0 in IDLE.
REQ-017 MTHI/MTLO: hi (or lo) <= rs on the accepting edge; no busy; done=0; the FSM stays in IDLE.
REQ-018 Reserved op codes: no state change, no done pulse, hi/lo unchanged.
REQ-019 MULT/MULTU: IDLE->MUL on accept at edge k; {hi,lo} <= 2*WIDTH-bit product at edge k+MUL_LAT; MUL->IDLE at that same edge.
REQ-020 MULT treats rs and rt as two's complement; MULTU treats them as unsigned; the full 2*WIDTH-bit product is kept, no truncation.
REQ-021 DIV/DIVU, divisor nonzero: IDLE->DIV on accept at edge k.
- Restoring division, 1 quotient bit per cycle, WIDTH iterations on unsigned magnitudes.
- DIV->FIX after the last iteration.
- FIX applies the sign correction, then FIX->IDLE.
- lo=quotient, hi=remainder, both committed at edge k+WIDTH+1.
REQ-022 Signed DIV rules: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-023 DIV with rs=most-negative and rt=-1: lo=most-negative value, hi=0, dz=0.
REQ-024 Divide by zero (DIV or DIVU, rt=0): commit at edge k+1 with lo=all ones, hi=rs, dz=1; MUL/DIV states are skipped.
REQ-025 Operands are captured internally at accept; rs/rt may change at any time afterwards.
REQ-026 done=1 for exactly the one cycle following the commit edge, with busy=0 in that cycle; a new start in that cycle is accepted.
REQ-027 dz=0 whenever done=0.
REQ-028 hi/lo hold their previous values throughout busy and change only at the commit edge.
REQ-029 Cancel while busy: at the next edge the FSM returns to IDLE; no commit, no done, hi/lo unchanged.
REQ-030 Cancel in IDLE has no effect, but suppresses a start on the same edge.
REQ-031 Cancel on the commit edge takes priority: the result is discarded and no done pulse is produced.
REQ-032 The iteration counter is ceil(log2(WIDTH+1)) bits wide and never wraps within one operation.

Reset
REQ-033 RST low asynchronously forces, without waiting for a clock edge: state=IDLE, hi=0, lo=0, busy=0, done=0, dz=0, and the counter and internal operand registers to 0.
REQ-034 Reset mid-operation abandons the operation; no done pulse follows the release of reset.
REQ-035 The first accept is possible on the first rising edge after RST goes high.

Verification (WIDTH=32, MUL_LAT=2)
REQ-036 MULT rs=FFFFFFFF rt=00000002 at edge k -> hi=FFFFFFFF, lo=FFFFFFFE at edge k+2; done during cycle k+2..k+3.
REQ-037 MULTU with the same operands -> hi=00000001, lo=FFFFFFFE; busy=1 for exactly 2 cycles.
REQ-038 DIV rs=FFFFFFF9 (-7) rt=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF at edge k+33; DIVU 7/3 -> lo=2, hi=1.
REQ-039 DIVU rs=00000007 rt=0 -> at edge k+1 lo=FFFFFFFF, hi=00000007, with dz=1 and done=1 for one cycle.
REQ-040 DIV rs=80000000 rt=FFFFFFFF -> lo=80000000, hi=00000000, dz=0.
REQ-041 Cancel and reset:
- DIV started, cancel asserted in its 10th busy cycle -> busy=0 next cycle, no done, hi/lo retain prior values.
- Repeat with RST pulsed low instead -> hi=lo=0 immediately.
- MTHI with start held through an in-flight MULT -> ignored until busy=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO result registers.
// Multi-cycle MUL and restoring DIV, with cancel and divide-by-zero handling.
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sgn_q, sgn_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dzf_q, dzf_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic               accept;
    logic               div_sgn;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH:0]     shl, diff;
    logic               geq;
    logic [WIDTH-1:0]   q_fix, r_fix;

    always_comb begin
        accept  = start && !cancel && (state_q == S_IDLE);
        div_sgn = (op == OP_DIV);
        a_ext = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q}
                      : {{WIDTH{1'b0}}, a_q};
        b_ext = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q}
                      : {{WIDTH{1'b0}}, b_q};
        prod  = a_ext * b_ext;
        // a_q doubles as the shift register that collects quotient bits
        shl   = {rem_q, a_q[WIDTH-1]};
        diff  = shl - {1'b0, b_q};
        geq   = !diff[WIDTH];
        q_fix = qneg_q ? -a_q : a_q;
        r_fix = rneg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dzf_d   = dzf_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d = S_MUL;
                            cnt_d   = CW'(MUL_LAT - 1);
                            a_d     = rs;
                            b_d     = rt;
                            sgn_d   = (op == OP_MULT);
                        end
                        OP_DIV, OP_DIVU: begin
                            rem_d = '0;
                            if (rt == '0) begin
                                state_d = S_FIX;
                                dzf_d   = 1'b1;
                                a_d     = rs;
                                b_d     = '0;
                                qneg_d  = 1'b0;
                                rneg_d  = 1'b0;
                            end else begin
                                state_d = S_DIV;
                                cnt_d   = CW'(WIDTH);
                                dzf_d   = 1'b0;
                                a_d     = (div_sgn && rs[WIDTH-1]) ? -rs : rs;
                                b_d     = (div_sgn && rt[WIDTH-1]) ? -rt : rt;
                                qneg_d  = div_sgn && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                                rneg_d  = div_sgn && rs[WIDTH-1];
                            end
                        end
                        OP_MTHI: hi_d = rs;
                        OP_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d      = S_IDLE;
                    {hi_d, lo_d} = prod;
                    done_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = geq ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], geq};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (dzf_q) begin
                        lo_d = '1;
                        hi_d = a_q;
                        dz_d = 1'b1;
                    end else begin
                        lo_d = q_fix;
                        hi_d = r_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dzf_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dzf_q   <= dzf_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32, MUL_LAT=2).
// Inputs change #1 after a rising edge; outputs are checked there too.
module tb_muldiv_unit;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;
    int n, bc, dcnt;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .dz     (dz),
        .hi     (hi),
        .lo     (lo)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // one-cycle request; operands are scrambled afterwards
    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        op    = o;
        rs    = a;
        rt    = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        rs    = $urandom;
        rt    = $urandom;
    endtask

    task automatic wait_done(output int cyc, output int bcy);
        cyc = 0;
        bcy = 0;
        while (!done && cyc < 100) begin
            if (busy) bcy++;
            tick();
            cyc++;
        end
    endtask

    task automatic quiet(input int cycles, output int dseen);
        dseen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) dseen++;
        end
    endtask

    initial begin
        RST    = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        rs     = '0;
        rt     = '0;
        cancel = 1'b0;
        #2;
        chk("rst_hi",   64'(hi),   64'h0);
        chk("rst_lo",   64'(lo),   64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_dz",   64'(dz),   64'h0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;

        issue(3'd4, 32'h55, 32'h0);
        chk("mthi_first", 64'(hi), 64'h55);
        chk("mthi_busy",  64'(busy), 64'h0);
        issue(3'd5, 32'h66, 32'h0);
        chk("mtlo", 64'(lo), 64'h66);
        chk("mtlo_done", 64'(done), 64'h0);

        issue(3'd0, 32'hFFFFFFFF, 32'h2);
        chk("mult_busy", 64'(busy), 64'h1);
        chk("mult_hold", 64'(hi), 64'h55);
        wait_done(n, bc);
        chk("mult_lat", 64'(n), 64'd2);
        chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult_lo", 64'(lo), 64'hFFFFFFFE);
        chk("mult_nb", 64'(busy), 64'h0);
        chk("mult_dz", 64'(dz), 64'h0);
        tick();
        chk("mult_pulse", 64'(done), 64'h0);

        issue(3'd1, 32'hFFFFFFFF, 32'h2);
        wait_done(n, bc);
        chk("multu_busy", 64'(bc), 64'd2);
        chk("multu_hi", 64'(hi), 64'h1);
        chk("multu_lo", 64'(lo), 64'hFFFFFFFE);
        tick();

        issue(3'd0, 32'hFFFFFFFD, 32'hFFFFFFFB);
        wait_done(n, bc);
        chk("mult_nn_hi", 64'(hi), 64'h0);
        chk("mult_nn_lo", 64'(lo), 64'hF);
        tick();

        issue(3'd2, 32'hFFFFFFF9, 32'h2);
        chk("div_hold", 64'(lo), 64'hF);
        wait_done(n, bc);
        chk("div_lat", 64'(n), 64'd33);
        chk("div_lo", 64'(lo), 64'hFFFFFFFD);
        chk("div_hi", 64'(hi), 64'hFFFFFFFF);
        tick();

        issue(3'd2, 32'h7, 32'hFFFFFFFE);
        wait_done(n, bc);
        chk("div_pn_lo", 64'(lo), 64'hFFFFFFFD);
        chk("div_pn_hi", 64'(hi), 64'h1);
        tick();

        issue(3'd3, 32'h7, 32'h3);
        wait_done(n, bc);
        chk("divu_lo", 64'(lo), 64'h2);
        chk("divu_hi", 64'(hi), 64'h1);
        tick();

        issue(3'd3, 32'h7, 32'h0);
        wait_done(n, bc);
        chk("dz_lat", 64'(n), 64'd1);
        chk("dz_lo", 64'(lo), 64'hFFFFFFFF);
        chk("dz_hi", 64'(hi), 64'h7);
        chk("dz_flag", 64'(dz), 64'h1);
        tick();
        chk("dz_done_off", 64'(done), 64'h0);
        chk("dz_flag_off", 64'(dz), 64'h0);

        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n, bc);
        chk("ovf_lo", 64'(lo), 64'h80000000);
        chk("ovf_hi", 64'(hi), 64'h0);
        chk("ovf_dz", 64'(dz), 64'h0);
        issue(3'd5, 32'h77, 32'h0);
        chk("b2b_lo", 64'(lo), 64'h77);

        issue(3'd6, 32'h1, 32'h1);
        chk("rsv_busy", 64'(busy), 64'h0);
        chk("rsv_lo", 64'(lo), 64'h77);
        tick();
        chk("rsv_done", 64'(done), 64'h0);

        cancel = 1'b1;
        issue(3'd5, 32'h99, 32'h0);
        cancel = 1'b0;
        chk("idle_cancel", 64'(lo), 64'h77);

        issue(3'd1, 32'h2, 32'h3);
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cc_done", 64'(done), 64'h0);
        chk("cc_busy", 64'(busy), 64'h0);
        chk("cc_lo", 64'(lo), 64'h77);
        tick();
        chk("cc_done2", 64'(done), 64'h0);

        issue(3'd4, 32'h1234, 32'h0);
        issue(3'd2, 32'd100, 32'd7);
        repeat (9) tick();
        chk("cdiv_busy10", 64'(busy), 64'h1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cdiv_busy", 64'(busy), 64'h0);
        quiet(40, dcnt);
        chk("cdiv_nodone", 64'(dcnt), 64'd0);
        chk("cdiv_hi", 64'(hi), 64'h1234);
        chk("cdiv_lo", 64'(lo), 64'h77);

        issue(3'd3, 32'd100, 32'd7);
        repeat (9) tick();
        RST = 1'b0;
        #1;
        chk("arst_hi", 64'(hi), 64'h0);
        chk("arst_lo", 64'(lo), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        tick();
        tick();
        RST = 1'b1;
        quiet(40, dcnt);
        chk("arst_nodone", 64'(dcnt), 64'd0);

        issue(3'd1, 32'h10000, 32'h30000);
        op    = 3'd4;
        rs    = 32'hABCD;
        start = 1'b1;
        tick();
        chk("held_k1_hi", 64'(hi), 64'h0);
        chk("held_k1_busy", 64'(busy), 64'h1);
        tick();
        chk("held_k2_hi", 64'(hi), 64'h3);
        chk("held_k2_lo", 64'(lo), 64'h0);
        chk("held_k2_done", 64'(done), 64'h1);
        tick();
        start = 1'b0;
        chk("held_k3_hi", 64'(hi), 64'hABCD);
        chk("held_k3_lo", 64'(lo), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
